seq_divider: RTL and testbench

- Multi-cycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions in the sequential processor.
- Adder/subtractor datapath used in the subtract direction: one trial subtraction per cycle.
- Sits beside the ALU; the control unit stalls on `busy` and writes back `result` when `done` pulses.

---
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One trial subtraction per cycle; signs are fixed up in a final cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_reg;
  logic [CW-1:0]    count_reg;
  logic [1:0]       op_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic [WIDTH-1:0] rem_reg;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] result_reg;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // Signed ops work on magnitudes; the most negative value maps onto itself,
  // which is still the correct unsigned magnitude.
  assign dividend_mag = (!op[0] && dividend[WIDTH-1]) ? -dividend : dividend;
  assign divisor_mag  = (!op[0] && divisor[WIDTH-1])  ? -divisor  : divisor;

  // Shifted-in partial remainder minus divisor, one bit wider so the MSB is the borrow.
  assign trial = {rem_reg, quo_reg[WIDTH-1]} - {1'b0, dvs_reg};

  assign q_fix = (!op_reg[0] && sign_q_reg) ? -quo_reg : quo_reg;
  assign r_fix = (!op_reg[0] && sign_r_reg) ? -rem_reg : rem_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      op_reg     <= '0;
      sign_q_reg <= 1'b0;
      sign_r_reg <= 1'b0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_reg <= op;
            if (divisor == '0) begin
              result_reg <= op[1] ? dividend : '1;
              state_reg  <= DONE;
            end else if (!op[0] && dividend == MIN_NEG && divisor == '1) begin
              result_reg <= op[1] ? '0 : MIN_NEG;
              state_reg  <= DONE;
            end else begin
              dvs_reg    <= divisor_mag;
              quo_reg    <= dividend_mag;
              rem_reg    <= '0;
              sign_q_reg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              sign_r_reg <= dividend[WIDTH-1];
              count_reg  <= CW'(WIDTH);
              state_reg  <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg   <= trial[WIDTH] ? {rem_reg[WIDTH-2:0], quo_reg[WIDTH-1]} : trial[WIDTH-1:0];
          quo_reg   <= {quo_reg[WIDTH-2:0], ~trial[WIDTH]};
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          result_reg <= op_reg[1] ? r_fix : q_fix;
          state_reg  <= DONE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_reg == CALC) || (state_reg == FIX);
  assign done   = (state_reg == DONE);
  assign result = result_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: expected results queued at request time,
// popped and compared when done pulses.
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          bcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one request; inj is the cycle (relative to the accept edge) in which
  // a stray start with junk operands is driven, 0 for none.
  task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp_res,
                     input int exp_lat, input int exp_bcnt, input int inj);
    int          cyc;
    int          bcnt;
    logic        hold_bad;
    logic [31:0] prev;
    exp_t        e;
    cyc      = 0;
    bcnt     = 0;
    hold_bad = 1'b0;
    exp_q.push_back('{res: exp_res, lat: exp_lat, bcnt: exp_bcnt});
    @(negedge clk);
    prev     = result;
    start    = 1'b1;
    op       = o;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    op       = 2'($urandom_range(3));
    dividend = $urandom;
    divisor  = $urandom;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == inj) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (busy) bcnt++;
      if (result !== prev) hold_bad = 1'b1;
    end
    e = exp_q.pop_front();
    $display("%s op=%0d a=%h b=%h result=%h latency=%0d busy_cycles=%0d",
             tag, o, a, b, result, cyc, bcnt);
    check({tag, "_result"}, result, e.res);
    check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check({tag, "_busy"}, 32'(bcnt), 32'(e.bcnt));
    check({tag, "_hold"}, {31'b0, hold_bad}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_after"}, {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int dones;
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    run("div_20_3",   2'b00, 32'd20,        32'd3,          32'd6,          34, 33, 5);
    run("rem_20_3",   2'b10, 32'd20,        32'd3,          32'd2,          34, 33, 0);
    run("div_m20_3",  2'b00, 32'hFFFFFFEC,  32'd3,          32'hFFFFFFFA,   34, 33, 0);
    run("rem_m20_3",  2'b10, 32'hFFFFFFEC,  32'd3,          32'hFFFFFFFE,   34, 33, 0);
    run("div_20_m3",  2'b00, 32'd20,        32'hFFFFFFFD,   32'hFFFFFFFA,   34, 33, 0);
    run("rem_20_m3",  2'b10, 32'd20,        32'hFFFFFFFD,   32'd2,          34, 33, 0);
    run("divu_max_2", 2'b01, 32'hFFFFFFFF,  32'd2,          32'h7FFFFFFF,   34, 33, 0);
    run("remu_max_2", 2'b11, 32'hFFFFFFFF,  32'd2,          32'd1,          34, 33, 34);
    run("div_m1_2",   2'b00, 32'hFFFFFFFF,  32'd2,          32'd0,          34, 33, 0);
    run("rem_m1_2",   2'b10, 32'hFFFFFFFF,  32'd2,          32'hFFFFFFFF,   34, 33, 0);
    run("div_7_0",    2'b00, 32'd7,         32'd0,          32'hFFFFFFFF,   1,  0,  1);
    run("rem_7_0",    2'b10, 32'd7,         32'd0,          32'd7,          1,  0,  0);
    run("divu_7_0",   2'b01, 32'd7,         32'd0,          32'hFFFFFFFF,   1,  0,  0);
    run("div_ovf",    2'b00, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   1,  0,  0);
    run("rem_ovf",    2'b10, 32'h80000000,  32'hFFFFFFFF,   32'd0,          1,  0,  0);
    run("divu_ovf",   2'b01, 32'h80000000,  32'hFFFFFFFF,   32'd0,          34, 33, 0);
    run("remu_ovf",   2'b11, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   34, 33, 0);
    run("div_1000_7", 2'b00, 32'd1000,      32'd7,          32'd142,        34, 33, 0);

    // Abort an operation with reset at cycle 10: nothing may complete.
    @(negedge clk);
    start    = 1'b1;
    op       = 2'b00;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("abort busy=%b done=%b result=%h", busy, done, result);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_result", result, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    run("post_rst_div", 2'b00, 32'd100, 32'd7, 32'd14, 34, 33, 0);
    run("post_rst_rem", 2'b10, 32'd100, 32'd7, 32'd2,  34, 33, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
